branch_predict_unit: RTL and testbench

Parametrised successor to the single-cycle branch resolver. It adds a per-PC table of 2-bit saturating counters that predicts branches at fetch, resolves them in EX, and issues a redirect and flush on a mispredict. A sticky halt state machine is also new. The block sits between IF (prediction lookup) and EX (resolution and table update) of the RISC-V pipeline.

---
 rtl/branch_pkg.sv | 42 ++++
 rtl/bht_table.sv | 45 ++++
 rtl/branch_predict_unit.sv | 175 +++++++++++++++++
 tb/tb_branch_predict_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pkg
//  Description : Shared types and helpers for the branch prediction unit:
//                2-bit saturating counter type and encodings, the run/halt
//                state type, and the counter update function.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

    // 2-bit saturating counter. Bit 1 set means "predict taken".
    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'd0;    // strongly not-taken
    localparam ctr_t CTR_WNT = 2'd1;    // weakly not-taken (reset value)
    localparam ctr_t CTR_WT  = 2'd2;    // weakly taken
    localparam ctr_t CTR_ST  = 2'd3;    // strongly taken

    typedef enum logic [0:0] {
        BPU_RUN    = 1'b0,
        BPU_HALTED = 1'b1
    } bpu_state_t;

    // Move a counter one step toward the resolved direction, clamping at
    // both ends so a single outlier never flips a strongly biased entry.
    function automatic ctr_t sat_update(input ctr_t c, input logic taken);
        ctr_t r;
        r = c;
        if (taken) begin
            if (c != CTR_ST) begin
                r = ctr_t'(c + 2'd1);
            end
        end else begin
            if (c != CTR_SNT) begin
                r = ctr_t'(c - 2'd1);
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bht_table.sv
`default_nettype none
// ============================================================================
//  Module      : bht_table
//  Description : Branch history table of BHT_DEPTH 2-bit saturating
//                counters. One combinational read port (fetch lookup) and
//                one registered read-modify-write update port (EX resolve).
//                A lookup of the entry being updated in the same cycle sees
//                the pre-update value; the new value is visible next cycle.
//  Ports       : clk, rst_n           - clock, async active-low reset
//                i_rd_idx / o_rd_ctr  - lookup index / counter value
//                i_upd_en             - apply an update this cycle
//                i_upd_idx            - entry to update
//                i_upd_taken          - resolved direction
//  Revision    : 1.0 - initial release
// ============================================================================
module bht_table
    import branch_pkg::*;
#(
    parameter int BHT_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [$clog2(BHT_DEPTH)-1:0] i_rd_idx,
    output ctr_t                         o_rd_ctr,
    input  logic                         i_upd_en,
    input  logic [$clog2(BHT_DEPTH)-1:0] i_upd_idx,
    input  logic                         i_upd_taken
);

    ctr_t r_ctr [BHT_DEPTH];

    assign o_rd_ctr = r_ctr[i_rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_ctr[i] <= CTR_WNT;
            end
        end else if (i_upd_en) begin
            r_ctr[i_upd_idx] <= sat_update(r_ctr[i_upd_idx], i_upd_taken);
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predict_unit
//  Description : Branch predictor / resolver between IF and EX. Predicts
//                conditional branches at fetch from a table of 2-bit
//                saturating counters, resolves them in EX, and issues a
//                redirect plus IF/ID flush on a mispredict. A sticky halt
//                state redirects fetch to the halting PC until reset.
//  Options     : define BRANCH_STATS_EN to add saturating branch and
//                mispredict counters (stat_branches / stat_mispredicts).
//  Ports       : IF side : if_pc, if_imm, if_is_branch -> pred_taken,
//                          pred_target
//                EX side : ex_valid, ex_pc, ex_imm, ex_branch,
//                          ex_alu_result, ex_pred_taken, halt -> pc_sel,
//                          br_pc, pc_four, flush, halted
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int PC_W      = 9,
    parameter int BHT_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    // fetch-side lookup
    input  logic [PC_W-1:0] if_pc,
    input  logic [31:0]     if_imm,
    input  logic            if_is_branch,
    output logic            pred_taken,
    output logic [31:0]     pred_target,
    // execute-side resolution
    input  logic            ex_valid,
    input  logic [PC_W-1:0] ex_pc,
    input  logic [31:0]     ex_imm,
    input  logic            ex_branch,
    input  logic [31:0]     ex_alu_result,
    input  logic            ex_pred_taken,
    input  logic            halt,
    output logic            pc_sel,
    output logic [31:0]     br_pc,
    output logic [31:0]     pc_four,
    output logic            flush,
`ifdef BRANCH_STATS_EN
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts,
`endif
    output logic            halted
);

    localparam int c_IDX_W = $clog2(BHT_DEPTH);

    bpu_state_t r_state;
    logic [31:0] r_hold_pc;

    logic [31:0]        w_if_pc32;
    logic [31:0]        w_ex_pc32;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic [c_IDX_W-1:0] w_upd_idx;
    ctr_t               w_rd_ctr;
    logic               w_actual;
    logic               w_mispredict;
    logic               w_run;
    logic               w_upd_en;
    logic               w_unused_alu;

    assign w_if_pc32 = 32'(if_pc);
    assign w_ex_pc32 = 32'(ex_pc);

    // Word-aligned index: drop the two byte-offset bits.
    assign w_rd_idx  = if_pc[c_IDX_W+1:2];
    assign w_upd_idx = ex_pc[c_IDX_W+1:2];

    // Only bit 0 of the ALU result carries the branch condition.
    assign w_unused_alu = ^ex_alu_result[31:1];

    // ------------------------------------------------------------------
    // Counter table
    // ------------------------------------------------------------------
    bht_table #(
        .BHT_DEPTH (BHT_DEPTH)
    ) u_bht (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rd_idx    (w_rd_idx),
        .o_rd_ctr    (w_rd_ctr),
        .i_upd_en    (w_upd_en),
        .i_upd_idx   (w_upd_idx),
        .i_upd_taken (w_actual)
    );

    // ------------------------------------------------------------------
    // Fetch-side prediction
    // ------------------------------------------------------------------
    assign pred_taken  = if_is_branch & w_rd_ctr[1];
    assign pred_target = pred_taken ? (w_if_pc32 + if_imm)
                                    : (w_if_pc32 + 32'd4);

    // ------------------------------------------------------------------
    // Execute-side resolution
    // ------------------------------------------------------------------
    assign w_run        = (r_state == BPU_RUN);
    assign w_actual     = ex_branch & ex_alu_result[0];
    assign w_mispredict = ex_valid & ex_branch & (w_actual != ex_pred_taken);

    // A halt request suppresses the table update of a branch resolving in
    // the same cycle; once halted the EX inputs are ignored entirely.
    assign w_upd_en = w_run & ~halt & ex_valid & ex_branch;

    assign pc_four = w_ex_pc32 + 32'd4;
    assign halted  = ~w_run;

    // Priority: halted state, then a fresh halt request, then mispredict.
    always_comb begin
        pc_sel = 1'b0;
        flush  = 1'b0;
        br_pc  = 32'd0;
        if (!w_run) begin
            pc_sel = 1'b1;
            br_pc  = r_hold_pc;
        end else if (halt) begin
            pc_sel = 1'b1;
            br_pc  = w_ex_pc32;
        end else if (w_mispredict) begin
            pc_sel = 1'b1;
            flush  = 1'b1;
            br_pc  = w_actual ? (w_ex_pc32 + ex_imm) : (w_ex_pc32 + 32'd4);
        end
    end

    // ------------------------------------------------------------------
    // Run / halt state. HALTED is sticky; only reset leaves it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= BPU_RUN;
            r_hold_pc <= 32'd0;
        end else if (w_run && halt) begin
            r_state   <= BPU_HALTED;
            r_hold_pc <= w_ex_pc32;
        end
    end

`ifdef BRANCH_STATS_EN
    // ------------------------------------------------------------------
    // Statistics: branches = table updates, mispredicts = flushes issued.
    // Both saturate and naturally freeze in HALTED since neither event
    // can occur there.
    // ------------------------------------------------------------------
    logic [31:0] r_stat_br;
    logic [31:0] r_stat_mp;
    logic        w_mp_count;

    assign w_mp_count = w_run & ~halt & w_mispredict;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_br <= 32'd0;
            r_stat_mp <= 32'd0;
        end else begin
            if (w_upd_en && (r_stat_br != 32'hFFFF_FFFF)) begin
                r_stat_br <= r_stat_br + 32'd1;
            end
            if (w_mp_count && (r_stat_mp != 32'hFFFF_FFFF)) begin
                r_stat_mp <= r_stat_mp + 32'd1;
            end
        end
    end

    assign stat_branches    = r_stat_br;
    assign stat_mispredicts = r_stat_mp;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predict_unit
//  Description : Self-checking bench for branch_predict_unit. A table of
//                one-cycle vectors with hand-computed outputs covers
//                prediction, mispredict redirect, saturation and aliasing;
//                hand-written sequences cover halt and reset behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_unit;

    localparam int PC_W      = 9;
    localparam int BHT_DEPTH = 16;

    logic            clk;
    logic            rst_n;
    logic [PC_W-1:0] if_pc;
    logic [31:0]     if_imm;
    logic            if_is_branch;
    logic            pred_taken;
    logic [31:0]     pred_target;
    logic            ex_valid;
    logic [PC_W-1:0] ex_pc;
    logic [31:0]     ex_imm;
    logic            ex_branch;
    logic [31:0]     ex_alu_result;
    logic            ex_pred_taken;
    logic            halt;
    logic            pc_sel;
    logic [31:0]     br_pc;
    logic [31:0]     pc_four;
    logic            flush;
    logic            halted;
`ifdef BRANCH_STATS_EN
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispredicts;
`endif

    branch_predict_unit #(
        .PC_W      (PC_W),
        .BHT_DEPTH (BHT_DEPTH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc            (if_pc),
        .if_imm           (if_imm),
        .if_is_branch     (if_is_branch),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_imm           (ex_imm),
        .ex_branch        (ex_branch),
        .ex_alu_result    (ex_alu_result),
        .ex_pred_taken    (ex_pred_taken),
        .halt             (halt),
        .pc_sel           (pc_sel),
        .br_pc            (br_pc),
        .pc_four          (pc_four),
        .flush            (flush),
`ifdef BRANCH_STATS_EN
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts),
`endif
        .halted           (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PC_W-1:0] if_pc;
        logic [31:0]     if_imm;
        logic            if_br;
        logic            ex_v;
        logic [PC_W-1:0] ex_pc;
        logic [31:0]     ex_imm;
        logic            ex_br;
        logic            alu0;
        logic            ex_pt;
        logic            halt;
        logic            e_pt;
        logic [31:0]     e_tgt;
        logic            e_sel;
        logic [31:0]     e_brpc;
        logic            e_flush;
        logic            e_halted;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic vec_t mk(
        input logic [PC_W-1:0] a_if_pc, input logic [31:0] a_if_imm,
        input logic a_if_br, input logic a_ex_v,
        input logic [PC_W-1:0] a_ex_pc, input logic [31:0] a_ex_imm,
        input logic a_ex_br, input logic a_alu0, input logic a_ex_pt,
        input logic a_halt, input logic a_e_pt, input logic [31:0] a_e_tgt,
        input logic a_e_sel, input logic [31:0] a_e_brpc,
        input logic a_e_flush, input logic a_e_halted);
        vec_t v;
        v.if_pc = a_if_pc;   v.if_imm = a_if_imm; v.if_br = a_if_br;
        v.ex_v  = a_ex_v;    v.ex_pc  = a_ex_pc;  v.ex_imm = a_ex_imm;
        v.ex_br = a_ex_br;   v.alu0   = a_alu0;   v.ex_pt  = a_ex_pt;
        v.halt  = a_halt;    v.e_pt   = a_e_pt;   v.e_tgt  = a_e_tgt;
        v.e_sel = a_e_sel;   v.e_brpc = a_e_brpc; v.e_flush = a_e_flush;
        v.e_halted = a_e_halted;
        return v;
    endfunction

    task automatic check(input string name, input int id,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got 0x%08h, expected 0x%08h",
                     name, id, act, exp);
        end
    endtask

    // Drive a vector at the falling edge, let it settle, check the
    // combinational outputs; the following rising edge applies updates.
    task automatic apply(input vec_t v, input logic rst_val, input int id);
        logic [31:0] exp_four;
        @(negedge clk);
        rst_n         = rst_val;
        if_pc         = v.if_pc;
        if_imm        = v.if_imm;
        if_is_branch  = v.if_br;
        ex_valid      = v.ex_v;
        ex_pc         = v.ex_pc;
        ex_imm        = v.ex_imm;
        ex_branch     = v.ex_br;
        ex_alu_result = {31'h2AAA_5555, v.alu0};
        ex_pred_taken = v.ex_pt;
        halt          = v.halt;
        #1;
        exp_four = 32'(v.ex_pc) + 32'd4;
        check("pred_taken",  id, 32'(pred_taken),  32'(v.e_pt));
        check("pred_target", id, pred_target,      v.e_tgt);
        check("pc_sel",      id, 32'(pc_sel),      32'(v.e_sel));
        check("br_pc",       id, br_pc,            v.e_brpc);
        check("flush",       id, 32'(flush),       32'(v.e_flush));
        check("halted",      id, 32'(halted),      32'(v.e_halted));
        check("pc_four",     id, pc_four,          exp_four);
    endtask

    vec_t vecs [19];
    vec_t hv   [4];

    initial begin
        rst_n = 1'b0;
        if_pc = '0; if_imm = '0; if_is_branch = 1'b0;
        ex_valid = 1'b0; ex_pc = '0; ex_imm = '0; ex_branch = 1'b0;
        ex_alu_result = '0; ex_pred_taken = 1'b0; halt = 1'b0;

        //            if_pc   if_imm        ifb exv ex_pc   ex_imm        exb a0 ept hlt  ept tgt          sel brpc         fl hal
        // fresh table: weak-NT everywhere
        vecs[0]  = mk(9'h020, 32'h100,      1, 0, 9'h000, 32'h0,        0, 0, 0, 0,  0, 32'h24,      0, 32'h0,        0, 0);
        // mispredict taken at 0x20; same-cycle lookup sees old counter
        vecs[1]  = mk(9'h020, 32'h100,      1, 1, 9'h020, 32'h10,       1, 1, 0, 0,  0, 32'h24,      1, 32'h30,       1, 0);
        vecs[2]  = mk(9'h020, 32'h100,      1, 0, 9'h000, 32'h0,        0, 0, 0, 0,  1, 32'h120,     0, 32'h0,        0, 0);
        // saturation at 0x40: 1->2->3->3->3 then down
        vecs[3]  = mk(9'h040, 32'h20,       1, 1, 9'h040, 32'h8,        1, 1, 0, 0,  0, 32'h44,      1, 32'h48,       1, 0);
        vecs[4]  = mk(9'h040, 32'h20,       1, 1, 9'h040, 32'h8,        1, 1, 1, 0,  1, 32'h60,      0, 32'h0,        0, 0);
        vecs[5]  = vecs[4];
        vecs[6]  = vecs[4];
        vecs[7]  = mk(9'h040, 32'h20,       1, 1, 9'h040, 32'h8,        1, 0, 1, 0,  1, 32'h60,      1, 32'h44,       1, 0);
        vecs[8]  = mk(9'h040, 32'h20,       1, 0, 9'h000, 32'h0,        0, 0, 0, 0,  1, 32'h60,      0, 32'h0,        0, 0);
        // non-branch fetch never predicts taken
        vecs[9]  = mk(9'h040, 32'h20,       0, 0, 9'h000, 32'h0,        0, 0, 0, 0,  0, 32'h44,      0, 32'h0,        0, 0);
        vecs[10] = vecs[7];
        vecs[11] = mk(9'h040, 32'h20,       1, 0, 9'h000, 32'h0,        0, 0, 0, 0,  0, 32'h44,      0, 32'h0,        0, 0);
        // aliasing: 0x44 and 0x04 share entry 1
        vecs[12] = mk(9'h004, 32'h10,       1, 1, 9'h044, 32'h4,        1, 1, 0, 0,  0, 32'h08,      1, 32'h48,       1, 0);
        vecs[13] = mk(9'h004, 32'h10,       1, 0, 9'h000, 32'h0,        0, 0, 0, 0,  1, 32'h14,      0, 32'h0,        0, 0);
        // correct not-taken at 0x60 (aliases 0x20): no redirect, entry 2->1
        vecs[14] = mk(9'h020, 32'h100,      1, 1, 9'h060, 32'h8,        1, 0, 0, 0,  1, 32'h120,     0, 32'h0,        0, 0);
        vecs[15] = mk(9'h020, 32'h100,      1, 0, 9'h000, 32'h0,        0, 0, 0, 0,  0, 32'h24,      0, 32'h0,        0, 0);
        // ex_valid low: no redirect, no update
        vecs[16] = mk(9'h020, 32'h100,      1, 0, 9'h020, 32'h10,       1, 1, 0, 0,  0, 32'h24,      0, 32'h0,        0, 0);
        vecs[17] = vecs[15];
        // 32-bit wrap of branch target
        vecs[18] = mk(9'h000, 32'h0,        0, 1, 9'h1F0, 32'hFFFF_FFF0, 1, 1, 0, 0,  0, 32'h4,       1, 32'h1E0,      1, 0);

        // Halt sequence (entry 0 holds weak-NT at this point)
        hv[0] = mk(9'h080, 32'h10, 1, 1, 9'h080, 32'h10, 1, 1, 0, 1,  0, 32'h84, 1, 32'h80, 0, 0);
        hv[1] = mk(9'h080, 32'h10, 1, 1, 9'h100, 32'h10, 1, 1, 0, 0,  0, 32'h84, 1, 32'h80, 0, 1);
        hv[2] = mk(9'h080, 32'h10, 1, 1, 9'h0C0, 32'h10, 1, 1, 0, 1,  0, 32'h84, 1, 32'h80, 0, 1);
        hv[3] = mk(9'h080, 32'h10, 1, 0, 9'h000, 32'h0,  0, 0, 0, 0,  0, 32'h84, 1, 32'h80, 0, 1);

        // Reset state with idle EX inputs
        apply(mk(9'h020, 32'h100, 1, 0, 9'h000, 32'h0, 0, 0, 0, 0,
                 0, 32'h24, 0, 32'h0, 0, 0), 1'b0, 100);
`ifdef BRANCH_STATS_EN
        check("stat_branches_rst",    100, stat_branches,    32'd0);
        check("stat_mispredicts_rst", 100, stat_mispredicts, 32'd0);
`endif

        for (int i = 0; i < 19; i++) begin
            apply(vecs[i], 1'b1, i);
        end

        // Entry 1 is weak-T after aliasing; halt with a mispredicting branch
        for (int i = 0; i < 4; i++) begin
            apply(hv[i], 1'b1, 200 + i);
        end

        // Async reset from HALTED: immediate return to RUN, table cleared
        apply(mk(9'h004, 32'h10, 1, 0, 9'h000, 32'h0, 0, 0, 0, 0,
                 0, 32'h08, 0, 32'h0, 0, 0), 1'b0, 300);
        apply(mk(9'h004, 32'h10, 1, 0, 9'h000, 32'h0, 0, 0, 0, 0,
                 0, 32'h08, 0, 32'h0, 0, 0), 1'b1, 301);

        // Three branches, one mispredict
        apply(mk(9'h000, 32'h0, 0, 1, 9'h100, 32'h20, 1, 1, 0, 0,
                 0, 32'h4, 1, 32'h120, 1, 0), 1'b1, 400);
        apply(mk(9'h000, 32'h0, 0, 1, 9'h104, 32'h20, 1, 0, 0, 0,
                 0, 32'h4, 0, 32'h0, 0, 0), 1'b1, 401);
        apply(mk(9'h000, 32'h0, 0, 1, 9'h108, 32'h20, 1, 0, 0, 0,
                 0, 32'h4, 0, 32'h0, 0, 0), 1'b1, 402);
        apply(mk(9'h100, 32'h40, 1, 0, 9'h000, 32'h0, 0, 0, 0, 0,
                 1, 32'h140, 0, 32'h0, 0, 0), 1'b1, 403);
`ifdef BRANCH_STATS_EN
        check("stat_branches",    403, stat_branches,    32'd3);
        check("stat_mispredicts", 403, stat_mispredicts, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
